// File: rtl/gpr_regfile_mp_pkg.sv
// Shared rfPhoenix definitions used by the general register file: the clear
// engine state type, the core-wide Value type and the thread/register counts
// the instantiating core passes as parameter defaults.
package rfPhoenixPkg;

   localparam int NTHREADS = 4;
   localparam int NREGS    = 64;
   localparam int TidMSB   = $clog2(NTHREADS) - 1;

   typedef logic [31:0] Value;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLR_ALL = 2'd1,
      CLR_THR = 2'd2
   } gpr_clr_state_t;

endpackage

// File: rtl/gpr_regfile_mp_ram.sv
// gpr_ram_sdp: one simple-dual-port RAM copy of the register file.
// Byte-lane write enables on the write port; the read port samples its
// address on the clock edge and returns the contents as they stood before
// any write landing on that same edge (read-first).
module gpr_ram_sdp #(
   parameter int AW  = 8,
   parameter int WID = 32,
   localparam int NB = WID / 8
)(
   input  logic           clk,
   input  logic [NB-1:0]  i_we,
   input  logic [AW-1:0]  i_wa,
   input  logic [WID-1:0] i_wd,
   input  logic [AW-1:0]  i_ra,
   output logic [WID-1:0] o_rd
);

   // NOTE: the storage array has no reset; the clear engine in the top level
   // zeroes it by writing every word, which keeps this mappable to block RAM.
   logic [WID-1:0] r_mem [2**AW];
   logic [WID-1:0] r_rd;

   // Byte-masked write and read-first registered read.
   // NOTE: sequential state uses non-blocking assignments so the read below
   // sees the pre-write word even when both ports hit the same address.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (i_we[b]) r_mem[i_wa][b*8 +: 8] <= i_wd[b*8 +: 8];
      end
      r_rd <= r_mem[i_ra];
   end

   assign o_rd = r_rd;

endmodule

// File: rtl/gpr_regfile_mp.sv
// gpr_regfile_mp: per-thread general register file with NRD read ports.
// One RAM copy per read port, all written together. A clear engine owns the
// write port after reset (whole file) or on clr_req (one thread).
// Build option: define GPR_BYPASS_EN for write-first read/write collisions;
// left undefined, collisions read the pre-write contents and no forwarding
// logic exists.
module gpr_regfile_mp
   import rfPhoenixPkg::*;
#(
   parameter int  NTHR        = NTHREADS,
   parameter int  NREG        = NREGS,
   parameter int  WID         = $bits(Value),
   parameter int  NRD         = 3,
   parameter bit  ZERO_BYPASS = 1'b1,
   localparam int TW          = (NTHR > 1) ? $clog2(NTHR) : 1,
   localparam int RW          = $clog2(NREG),
   localparam int AW          = $clog2(NTHR) + RW,
   localparam int NB          = WID / 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NB-1:0]      wr,
   input  logic [AW-1:0]      wa,
   input  logic [WID-1:0]     i,
   input  logic [NRD*AW-1:0]  ra,
   output logic [NRD*WID-1:0] o,
   input  logic               clr_req,
   input  logic [TW-1:0]      clr_tid,
   output logic               busy
);

   gpr_clr_state_t r_state;
   logic [AW-1:0]  r_ptr;
   logic           r_busy;

   logic [NB-1:0]  w_we;
   logic [AW-1:0]  w_wa;
   logic [WID-1:0] w_wd;

   // Clear engine: walks r_ptr over the whole file or one thread, one word
   // per cycle; busy is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLR_ALL;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state <= CLR_THR;
                  r_ptr   <= AW'(clr_tid) << RW;
                  r_busy  <= 1'b1;
               end
            end
            CLR_ALL: begin
               if (r_ptr == '1) begin
                  r_state <= IDLE;
                  r_ptr   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + AW'(1);
               end
            end
            CLR_THR: begin
               if (r_ptr[RW-1:0] == '1) begin
                  r_state <= IDLE;
                  r_ptr   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + AW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_ptr   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;

   // Write-port mux: the clear engine takes the port and writes zero to all
   // lanes; writeback traffic arriving meanwhile is dropped.
   // NOTE: every output gets a default at the top of always_comb so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_we = wr;
      w_wa = wa;
      w_wd = i;
      if (r_busy) begin
         w_we = '1;
         w_wa = r_ptr;
         w_wd = '0;
      end
   end

`ifdef GPR_BYPASS_EN
   logic [NB-1:0]  r_byp_be;
   logic [WID-1:0] r_byp_d;

   // Capture writeback lanes and data for forwarding to colliding reads.
   always_ff @(posedge clk) begin
      r_byp_be <= wr;
      r_byp_d  <= i;
   end
`endif

   for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [WID-1:0] w_rd;
      logic [WID-1:0] w_out;
      logic           r_zero;

      gpr_ram_sdp #(
         .AW  (AW),
         .WID (WID)
      ) u_ram (
         .clk  (clk),
         .i_we (w_we),
         .i_wa (w_wa),
         .i_wd (w_wd),
         .i_ra (ra[k*AW +: AW]),
         .o_rd (w_rd)
      );

      // Force zero while in reset and for register 0 of any thread.
      always_ff @(posedge clk) begin
         r_zero <= rst || (ZERO_BYPASS && (ra[k*AW +: RW] == '0));
      end

`ifdef GPR_BYPASS_EN
      logic r_hit;

      // Flag a same-edge writeback to the address this port is reading.
      always_ff @(posedge clk) begin
         r_hit <= !rst && !r_busy && (wr != '0) && (ra[k*AW +: AW] == wa);
      end

      // Merge forwarded lanes over the read-first RAM data.
      always_comb begin
         w_out = w_rd;
         if (r_hit) begin
            for (int b = 0; b < NB; b++) begin
               if (r_byp_be[b]) w_out[b*8 +: 8] = r_byp_d[b*8 +: 8];
            end
         end
      end
`else
      assign w_out = w_rd;
`endif

      assign o[k*WID +: WID] = r_zero ? '0 : w_out;
   end

endmodule

// File: tb/tb_gpr_regfile_mp.sv
// Self-checking bench for gpr_regfile_mp (default parameters). A word-level
// model tracks memory contents and a queue of addresses still to be zeroed;
// every cycle busy and all read ports are compared against it.
module tb_gpr_regfile_mp;

   localparam int NTHR = 4;
   localparam int NREG = 64;
   localparam int NWRD = NTHR * NREG;

   logic        clk;
   logic        rst;
   logic [3:0]  wr;
   logic [7:0]  wa;
   logic [31:0] wdat;
   logic [7:0]  ra_a [3];
   logic [23:0] ra;
   logic [95:0] o;
   logic        clr_req;
   logic [1:0]  clr_tid;
   logic        busy;

   assign ra = {ra_a[2], ra_a[1], ra_a[0]};

   gpr_regfile_mp dut (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .wa      (wa),
      .i       (wdat),
      .ra      (ra),
      .o       (o),
      .clr_req (clr_req),
      .clr_tid (clr_tid),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_mem   [NWRD];
   bit          m_known [NWRD];
   int          clr_q   [$];
   logic [31:0] fill_val [NWRD];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply one clock edge with the current inputs, update the model, then
   // compare busy and every read port whose expected word is known.
   task automatic step();
      logic [31:0] e_o [3];
      bit          e_k [3];
      bit          busy_pre;
      busy_pre = (clr_q.size() != 0);
      for (int k = 0; k < 3; k++) begin
         if (rst || (int'(ra_a[k]) % NREG == 0)) begin
            e_o[k] = 32'h0;
            e_k[k] = 1'b1;
         end else begin
            e_o[k] = m_mem[ra_a[k]];
            e_k[k] = m_known[ra_a[k]];
         end
      end
      if (busy_pre) begin
         int p;
         p = clr_q.pop_front();
         m_mem[p]   = 32'h0;
         m_known[p] = 1'b1;
      end else if (wr != 4'h0) begin
         for (int b = 0; b < 4; b++)
            if (wr[b]) m_mem[wa][b*8 +: 8] = wdat[b*8 +: 8];
         if (wr == 4'hF) m_known[wa] = 1'b1;
`ifdef GPR_BYPASS_EN
         for (int k = 0; k < 3; k++) begin
            if (!rst && (int'(ra_a[k]) % NREG != 0) && ra_a[k] == wa) begin
               e_o[k] = m_mem[wa];
               e_k[k] = m_known[wa];
            end
         end
`endif
      end
      if (rst) begin
         clr_q.delete();
         for (int a = 0; a < NWRD; a++) clr_q.push_back(a);
      end else if (!busy_pre && clr_req) begin
         clr_q.delete();
         for (int r = 0; r < NREG; r++) clr_q.push_back(int'(clr_tid) * NREG + r);
      end
      @(posedge clk);
      #1;
      check("busy", {31'h0, busy}, {31'h0, clr_q.size() != 0});
      for (int k = 0; k < 3; k++)
         if (e_k[k]) check($sformatf("o%0d", k), o[k*32 +: 32], e_o[k]);
   endtask

   task automatic rand_ra();
      for (int k = 0; k < 3; k++) ra_a[k] = 8'($urandom);
   endtask

   task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      wr   = be;
      wa   = a;
      wdat = d;
      step();
      wr   = 4'h0;
   endtask

   task automatic read_all_ports(input logic [7:0] a);
      for (int k = 0; k < 3; k++) ra_a[k] = a;
      step();
   endtask

   // Step while busy is high, counting cycles. Optionally pulse clr_req or
   // issue a writeback on a given cycle of the window.
   task automatic count_busy(output int n, input int pulse_at, input int write_at);
      n = 0;
      while (busy && n < 1000) begin
         rand_ra();
         if (n == pulse_at) begin
            clr_req = 1'b1;
            clr_tid = 2'($urandom);
         end
         if (n == write_at) begin
            wr   = 4'hF;
            wa   = 8'd9;
            wdat = 32'hDEAD_BEEF;
         end
         step();
         clr_req = 1'b0;
         wr      = 4'h0;
         n++;
      end
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      wr      = 4'h0;
      wa      = 8'h0;
      wdat    = 32'h0;
      clr_req = 1'b0;
      clr_tid = 2'd0;
      for (int k = 0; k < 3; k++) ra_a[k] = 8'h0;
      for (int a = 0; a < NWRD; a++) begin
         m_mem[a]   = 32'h0;
         m_known[a] = 1'b0;
      end

      // Reset for three cycles, then the full clear.
      for (int c = 0; c < 3; c++) begin
         rand_ra();
         step();
      end
      rst = 1'b0;
      count_busy(n, -1, -1);
      check("clr_all_len", n, 256);
      for (int a = 0; a < NWRD; a++) read_all_ports(8'(a));

      // Byte lanes.
      write_word({2'd1, 6'd5}, 32'hAABB_CCDD, 4'hF);
      write_word({2'd1, 6'd5}, 32'h1122_3344, 4'b0101);
      read_all_ports({2'd1, 6'd5});
      for (int k = 0; k < 3; k++)
         check($sformatf("lanes_p%0d", k), o[k*32 +: 32], 32'hAA22_CC44);

      // Multi-port read with zero bypass.
      write_word({2'd2, 6'd0}, 32'h5, 4'hF);
      write_word({2'd2, 6'd7}, 32'h7, 4'hF);
      write_word({2'd3, 6'd7}, 32'h9, 4'hF);
      ra_a[0] = {2'd2, 6'd0};
      ra_a[1] = {2'd2, 6'd7};
      ra_a[2] = {2'd3, 6'd7};
      step();
      check("zero_p0", o[31:0],  32'h0);
      check("mp_p1",   o[63:32], 32'h7);
      check("mp_p2",   o[95:64], 32'h9);

      // Same-edge write and read of one address.
      write_word({2'd0, 6'd3}, 32'h1, 4'hF);
      ra_a[0] = {2'd0, 6'd3};
      write_word({2'd0, 6'd3}, 32'hFF, 4'b0001);
`ifdef GPR_BYPASS_EN
      check("collide", o[31:0], 32'h0000_00FF);
`else
      check("collide", o[31:0], 32'h0000_0001);
`endif

      // Random writes, reads and collisions.
      for (int c = 0; c < 400; c++) begin
         wr   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         wa   = 8'($urandom);
         wdat = $urandom;
         for (int k = 0; k < 3; k++)
            ra_a[k] = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom);
         step();
      end
      wr = 4'h0;

      // Thread clear with a dropped write in the window.
      for (int a = 0; a < NWRD; a++) begin
         fill_val[a] = $urandom | 32'h1;
         write_word(8'(a), fill_val[a], 4'hF);
      end
      clr_req = 1'b1;
      clr_tid = 2'd2;
      rand_ra();
      step();
      clr_req = 1'b0;
      count_busy(n, -1, 10);
      check("clr_thr_len", n, 64);
      read_all_ports({2'd0, 6'd9});
      check("drop_wr", o[31:0], fill_val[9]);
      read_all_ports({2'd2, 6'd5});
      check("thr2_zero", o[31:0], 32'h0);
      read_all_ports({2'd3, 6'd7});
      check("thr3_keep", o[31:0], fill_val[199]);
      for (int a = 0; a < NWRD; a++) read_all_ports(8'(a));

      // Reset mid-clear, with clr_req pulses while busy.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         rand_ra();
         if (c == 50) begin
            clr_req = 1'b1;
            clr_tid = 2'd1;
         end
         step();
         clr_req = 1'b0;
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      count_busy(n, 30, -1);
      check("rst_mid_len", n, 256);
      for (int a = 0; a < NWRD; a++) read_all_ports(8'(a));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpr_regfile_mp.md
# gpr_regfile_mp

Multi-read-port, per-thread general register file for the rfPhoenix core. It holds NTHR×NREG words of WID bits with byte-lane write enables and NRD independent synchronous read ports. A built-in clear engine zeroes the whole file after reset, and can clear one thread's register set on request. It sits between the decode/operand-fetch stage, which drives the read ports, and writeback, which drives the write port.

## Interface
Parameters:
- NTHR, 4, hardware thread count (power of two, 1..16)
- NREG, 64, registers per thread (power of two)
- WID, 32, register width in bits (multiple of 8)
- NRD, 3, number of read ports (1..4)
- ZERO_BYPASS, 1, register index 0 always reads as zero

Ports (AW = $clog2(NTHR)+$clog2(NREG); address = {tid, regno}):
- clk  in  1  core clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  WID/8  byte-lane write enables
- wa  in  AW  write address
- i  in  WID  write data
- ra  in  NRD×AW  read addresses, port k at [k*AW +: AW]
- o  out  NRD×WID  read data, port k at [k*WID +: WID]
- clr_req  in  1  one-cycle pulse requesting a thread clear
- clr_tid  in  $clog2(NTHR)  thread to clear, sampled with clr_req
- busy  out  1  clear engine owns the write port

## Operation
- Storage: NRD identical RAM copies. Every write goes to all copies; copy k serves read port k.
- Write: for each lane b with wr[b]=1 and busy=0, mem[wa] byte b ← i byte b. Lanes with wr[b]=0 keep their old value.
- A write issued while busy=1 is dropped silently. Writeback must hold off while busy is high.
- Read: ra[k] is registered on each edge. o[k] = mem[ra_reg[k]].
- With ZERO_BYPASS=1 and ra_reg[k] regno field = 0, o[k] = 0 regardless of memory contents.
- Clear FSM states are IDLE, CLR_ALL and CLR_THR. A pointer ptr (AW bits) writes zero, all lanes, to mem[ptr] once per cycle.
  - rst → CLR_ALL with ptr=0. The FSM leaves CLR_ALL for IDLE after writing ptr = NTHR*NREG-1.
  - IDLE with clr_req → CLR_THR with ptr={clr_tid,0}. The FSM leaves CLR_THR for IDLE after writing ptr={clr_tid,NREG-1}.
  - clr_req while busy=1 is ignored and not queued.
- busy = (state != IDLE).
- Reads keep working during any clear. Reads of a thread being cleared may return a mix of old and zero data.

## Timing
- Reset values: state CLR_ALL, ptr=0, busy=1, all o=0.
- rst held high keeps ptr at 0, and address 0 is written with zero each cycle. rst asserted mid-clear restarts CLR_ALL at ptr=0.
- Full clear takes NTHR*NREG cycles after rst falls. busy drops in the cycle after the last write. Default parameters give 256 cycles.
- Thread clear: clr_req sampled at edge n gives busy=1 from n+1. Zero writes occur at edges n+1 .. n+NREG. busy=0 from n+NREG+1.
- Read latency is 1 cycle: ra presented at edge n gives o valid after edge n+1 until the next edge.
- Same-cycle write and read of one address: see Configuration.
- A write at edge n is always visible to a read whose address is registered at edge n+1 or later.

## Configuration
- GPR_BYPASS_EN defined: write-first behaviour. If wr≠0, busy=0 and ra[k]==wa at the same edge, o[k] shows the new bytes for enabled lanes and old bytes elsewhere. ZERO_BYPASS still takes precedence.
- GPR_BYPASS_EN undefined: read-first behaviour. In that collision o[k] shows the pre-write contents, and no forwarding mux is built.

## Structure
- Shared package rfPhoenixPkg holds:
  - typedef gpr_clr_state_t, with values IDLE, CLR_ALL, CLR_THR
  - the existing Value type and the NTHREADS, NREGS and TidMSB constants, used as parameter defaults by the instantiating core
- Sub-module gpr_ram_sdp: one simple-dual-port RAM with byte write enables and a registered read address, instantiated NRD times in a generate loop.
- Clear FSM, write-port mux, bypass logic and zero bypass live in the top module.

## Test plan
- Reset: pulse rst for 3 cycles. busy must stay 1 for exactly 256 cycles after rst falls. Reading each of the 256 addresses must then return 0.
- Byte lanes: write 0xAABBCCDD to {t1,r5} with wr=4'hF, then 0x11223344 with wr=4'b0101. A later read of {t1,r5} must return 0xAA22CC44 on all three ports.
- Multi-port and zero: port 0 reads {t2,r0}, port 1 reads {t2,r7}, port 2 reads {t3,r7}, after writing 0x5 to {t2,r0}, 0x7 to {t2,r7} and 0x9 to {t3,r7}. Outputs must be 0, 0x7 and 0x9.
- Collision: hold 0x1 in {t0,r3}, then at one edge write 0xFF to {t0,r3} with wr=4'b0001 and read it on port 0. Output must be 0x000000FF with GPR_BYPASS_EN and 0x00000001 without.
- Thread clear: fill all four threads with nonzero data, then pulse clr_req with clr_tid=2. busy must be high for exactly 64 cycles and a write issued during that window must be dropped. Afterwards thread 2 reads 0 and threads 0, 1 and 3 are unchanged.
- Reset mid-clear: assert rst 100 cycles into CLR_ALL, and also pulse clr_req during busy. The clear must restart at ptr=0, busy must last a full 256 cycles after rst falls, and the clr_req must have no effect.
